// File: rtl/bubble_flash_arbiter.sv
// bubble_flash_arbiter: shares one SPI flash bus between emulator and USB with
// fixed emulator priority, a CS-high guard gap between owners and a hold watchdog.
module bubble_flash_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int HOLD_W       = 16,
    parameter int MAX_HOLD     = 60000
) (
    input  logic MCLK,
    input  logic RST,
    input  logic EMU_REQ,
    output logic EMU_GNT,
    input  logic EMU_nCS,
    input  logic EMU_CLK,
    input  logic EMU_MOSI,
    input  logic EMU_OE,
    input  logic USB_REQ,
    output logic USB_GNT,
    input  logic USB_nCS,
    input  logic USB_CLK,
    input  logic USB_MOSI,
    input  logic USB_OE,
    output logic nROMCS,
    output logic ROMCLK,
    output logic ROMIO0_O,
    output logic ROMIO0_OE,
    output logic BUSY,
    output logic TIMEOUT_ERR,
    input  logic ERR_CLR
);
    typedef enum logic [1:0] {IDLE, EMU_OWN, USB_OWN, GUARD} state_t;
    localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              emu_lock_q, emu_lock_d, usb_lock_q, usb_lock_d, err_q, err_d;
    logic              owning, own_req, timeout;

    always_comb begin
        owning  = state_q == EMU_OWN || state_q == USB_OWN;
        own_req = state_q == EMU_OWN ? EMU_REQ : USB_REQ;
        // a voluntary release on the same edge as expiry is not an error
        timeout = MAX_HOLD > 0 && owning && own_req && hold_q == HOLD_W'(MAX_HOLD - 1);
        state_d = state_q;
        guard_d = '0;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (EMU_REQ && !emu_lock_q) state_d = EMU_OWN;
                else if (USB_REQ && !usb_lock_q) state_d = USB_OWN;
            end
            EMU_OWN, USB_OWN: begin
                hold_d = &hold_q ? hold_q : hold_q + 1'b1;
                if (!own_req || timeout) state_d = GUARD;
            end
            default: begin
                guard_d = guard_q + 1'b1;
                if (guard_q == GW'(GUARD_CYCLES - 1)) state_d = IDLE;
            end
        endcase
        emu_lock_d = (emu_lock_q && EMU_REQ) || (timeout && state_q == EMU_OWN);
        usb_lock_d = (usb_lock_q && USB_REQ) || (timeout && state_q == USB_OWN);
        err_d      = timeout || (err_q && !ERR_CLR);
    end

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            guard_q    <= '0;
            hold_q     <= '0;
            emu_lock_q <= 1'b0;
            usb_lock_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            hold_q     <= hold_d;
            emu_lock_q <= emu_lock_d;
            usb_lock_q <= usb_lock_d;
            err_q      <= err_d;
        end
    end

    // pin mux follows the registered state only, so it switches while pins are idle
    assign EMU_GNT     = state_q == EMU_OWN;
    assign USB_GNT     = state_q == USB_OWN;
    assign BUSY        = state_q != IDLE;
    assign TIMEOUT_ERR = err_q;
    assign nROMCS      = EMU_GNT ? EMU_nCS  : USB_GNT ? USB_nCS  : 1'b1;
    assign ROMCLK      = EMU_GNT ? EMU_CLK  : USB_GNT ? USB_CLK  : 1'b0;
    assign ROMIO0_O    = EMU_GNT ? EMU_MOSI : USB_GNT ? USB_MOSI : 1'b0;
    assign ROMIO0_OE   = EMU_GNT ? EMU_OE   : USB_GNT ? USB_OE   : 1'b0;
endmodule
